counter_gate_ctrl: RTL and testbench

- Timing-window controller that sits directly upstream and downstream of the input edge counter.
- Drives the counter's gate and clear inputs, then captures the counter's count at the end of each window.
- Publishes the captured count as a result with a one-cycle valid strobe.
- Supports single-shot and continuous back-to-back measurement windows of programmable length in i_clk cycles.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/counter_gate_ctrl_gate_timer.sv | 32 +++
 rtl/counter_gate_ctrl.sv | 112 +++++++++++
 tb/tb_counter_gate_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// counter_pkg : shared state type and default widths for the gate controller
// Revision    : 1.0
// ============================================================================
package counter_pkg;

  localparam int COUNT_W = 32;
  localparam int TIMER_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LATCH  = 3'd4
  } gate_state_t;

endpackage
`default_nettype wire

// File: rtl/counter_gate_ctrl_gate_timer.sv
`default_nettype none
// ============================================================================
// gate_timer : loadable down-counter that stops at zero and flags terminal count
// Revision   : 1.0
// ============================================================================
module gate_timer #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/counter_gate_ctrl.sv
`default_nettype none
// ============================================================================
// counter_gate_ctrl : gates and clears an edge counter, captures its count
//                     at the end of each programmable window
// Revision          : 1.0
// ============================================================================
module counter_gate_ctrl
  import counter_pkg::*;
#(
  parameter int CW     = COUNT_W,
  parameter int TW     = TIMER_W,
  parameter int SETTLE = 2,
  parameter int NW     = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_continuous,
  input  logic [TW-1:0] i_duration,
  input  logic [CW-1:0] i_count,
  output logic          o_gate,
  output logic          o_counter_reset,
  output logic          o_busy,
  output logic [CW-1:0] o_result,
  output logic          o_result_valid,
  output logic [NW-1:0] o_windows
);

  localparam int              SW          = $clog2(SETTLE + 1);
  localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [NW-1:0]   WINDOWS_MAX = '1;

  gate_state_t   state;
  logic          gate_done;
  logic          settle_done;
  logic [TW-1:0] gate_load;

  // A zero duration re-sampled on a continuous re-arm degrades to a
  // one-cycle window rather than wrapping the timer.
  assign gate_load = (i_duration == '0) ? '0 : i_duration - TW'(1);

  gate_timer #(.W(TW)) u_gate_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .load       (state == ST_CLEAR),
    .load_value (gate_load),
    .enable     (state == ST_GATE),
    .done       (gate_done)
  );

  // Reloaded on every gate cycle so it is primed on entry to SETTLE.
  gate_timer #(.W(SW)) u_settle_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .load       (state == ST_GATE),
    .load_value (SETTLE_LOAD),
    .enable     (state == ST_SETTLE),
    .done       (settle_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      o_windows      <= '0;
    end else begin
      o_result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start && !i_stop && (i_duration != '0)) begin
            state     <= ST_CLEAR;
            o_windows <= '0;
          end
        end
        ST_CLEAR: begin
          state <= i_stop ? ST_IDLE : ST_GATE;
        end
        ST_GATE: begin
          if (i_stop) begin
            state <= ST_IDLE;
          end else if (gate_done) begin
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (i_stop) begin
            state <= ST_IDLE;
          end else if (settle_done) begin
            state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          o_result       <= i_count;
          o_result_valid <= 1'b1;
          if (o_windows != WINDOWS_MAX) begin
            o_windows <= o_windows + NW'(1);
          end
          state <= (i_continuous && !i_stop) ? ST_CLEAR : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_gate          = (state == ST_GATE);
  assign o_counter_reset = (state == ST_CLEAR);
  assign o_busy          = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_counter_gate_ctrl.sv
`default_nettype none
// ============================================================================
// tb_counter_gate_ctrl : directed self-checking bench for counter_gate_ctrl
// Revision             : 1.0
// ============================================================================
module tb_counter_gate_ctrl;

  localparam int CW = 32;
  localparam int TW = 32;
  localparam int SETTLE = 2;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          continuous = 1'b0;
  logic [TW-1:0] duration = '0;
  logic          gate, counter_reset, busy, result_valid;
  logic [CW-1:0] result;
  logic [NW-1:0] windows;

  // Edge counter model fed by a signal toggling every clock
  logic          sig = 1'b0;
  logic [CW-1:0] model_cnt = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    sig <= ~sig;
    if (counter_reset) model_cnt <= '0;
    else if (gate && !sig) model_cnt <= model_cnt + 1;
  end

  counter_gate_ctrl #(.CW(CW), .TW(TW), .SETTLE(SETTLE), .NW(NW)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_start         (start),
    .i_stop          (stop),
    .i_continuous    (continuous),
    .i_duration      (duration),
    .i_count         (model_cnt),
    .o_gate          (gate),
    .o_counter_reset (counter_reset),
    .o_busy          (busy),
    .o_result        (result),
    .o_result_valid  (result_valid),
    .o_windows       (windows)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if ({gate, counter_reset, busy, result_valid} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_ctrl cycle %0d: got %b want 0000", c, {gate, counter_reset, busy, result_valid});
      end
    end
    total++;
    if (result !== '0) begin bad++; $display("FAIL reset_result: got %0d want 0", result); end
    total++;
    if (windows !== '0) begin bad++; $display("FAIL reset_windows: got %0d want 0", windows); end
  endtask

  task automatic test_single_shot();
    duration = 10;
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      start = 1'b0;
      total++;
      if (counter_reset !== (c == 1)) begin bad++; $display("FAIL single_clear cycle %0d: got %b want %b", c, counter_reset, c == 1); end
      total++;
      if (gate !== (c >= 2 && c <= 11)) begin bad++; $display("FAIL single_gate cycle %0d: got %b want %b", c, gate, c >= 2 && c <= 11); end
      total++;
      if (result_valid !== (c == 15)) begin bad++; $display("FAIL single_valid cycle %0d: got %b want %b", c, result_valid, c == 15); end
      total++;
      if (busy !== (c <= 14)) begin bad++; $display("FAIL single_busy cycle %0d: got %b want %b", c, busy, c <= 14); end
      if (c == 15) begin
        total++;
        if (result !== 32'd5) begin bad++; $display("FAIL single_result: got %0d want 5", result); end
        total++;
        if (windows !== 16'd1) begin bad++; $display("FAIL single_windows: got %0d want 1", windows); end
      end
    end
  endtask

  task automatic test_abort();
    duration = 100;
    start = 1'b1;
    for (int c = 1; c <= 51; c++) begin
      tick();
      start = 1'b0;
    end
    total++;
    if (gate !== 1'b1) begin bad++; $display("FAIL abort_pre_gate: got %b want 1", gate); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if ({gate, busy} !== 2'b00) begin bad++; $display("FAIL abort_stop: got gate/busy %b want 00", {gate, busy}); end
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (result_valid !== 1'b0) begin bad++; $display("FAIL abort_valid cycle %0d: got 1 want 0", c); end
    end
    total++;
    if (result !== 32'd5) begin bad++; $display("FAIL abort_result: got %0d want 5", result); end
    total++;
    if (windows !== 16'd0) begin bad++; $display("FAIL abort_windows: got %0d want 0", windows); end
  endtask

  task automatic test_continuous();
    int  run = 0;
    int  gap = 0;
    int  falls = 0;
    int  valids = 0;
    bit  prev = 1'b0;
    bit  idle = 1'b0;
    duration = 5;
    continuous = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 60 && !idle; c++) begin
      tick();
      start = 1'b0;
      if (result_valid) valids++;
      if (gate && !prev && falls > 0) begin
        total++;
        if (gap !== 4) begin bad++; $display("FAIL cont_gap: got %0d want 4", gap); end
      end
      if (!gate && prev) begin
        total++;
        if (run !== 5) begin bad++; $display("FAIL cont_run: got %0d want 5", run); end
        falls++;
        if (falls == 3) continuous = 1'b0;
      end
      run = gate ? (prev ? run + 1 : 1) : 0;
      gap = gate ? 0 : gap + 1;
      prev = gate;
      if (!busy && c > 2) idle = 1'b1;
    end
    total++;
    if (!idle) begin bad++; $display("FAIL cont_timeout: got busy want idle"); end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (result_valid) valids++;
      total++;
      if ({gate, busy} !== 2'b00) begin bad++; $display("FAIL cont_rearm: got gate/busy %b want 00", {gate, busy}); end
    end
    total++;
    if (valids !== 3) begin bad++; $display("FAIL cont_valids: got %0d want 3", valids); end
    total++;
    if (windows !== 16'd3) begin bad++; $display("FAIL cont_windows: got %0d want 3", windows); end
  endtask

  task automatic test_ignored_starts();
    int gcnt = 0;
    int clears = 0;
    duration = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ign_zero_dur: got busy 1 want 0"); end
    duration = 5;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ign_start_stop: got busy 1 want 0"); end
    duration = 6;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = (c == 4);
      if (c == 4) duration = 3;
      if (gate) gcnt++;
      if (counter_reset) clears++;
    end
    start = 1'b0;
    total++;
    if (gcnt !== 6) begin bad++; $display("FAIL ign_gate_len: got %0d want 6", gcnt); end
    total++;
    if (clears !== 1) begin bad++; $display("FAIL ign_clears: got %0d want 1", clears); end
    total++;
    if ({busy, windows} !== {1'b0, 16'd1}) begin bad++; $display("FAIL ign_end: got busy %b windows %0d want 0 1", busy, windows); end
  endtask

  task automatic test_min_window();
    duration = 1;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      total++;
      if (gate !== (c == 2)) begin bad++; $display("FAIL d1_gate cycle %0d: got %b want %b", c, gate, c == 2); end
      total++;
      if (result_valid !== (c == 6)) begin bad++; $display("FAIL d1_valid cycle %0d: got %b want %b", c, result_valid, c == 6); end
    end
  endtask

  task automatic test_reset_mid();
    duration = 50;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
    end
    total++;
    if (gate !== 1'b1) begin bad++; $display("FAIL rmid_pre_gate: got %b want 1", gate); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({gate, counter_reset, busy, result_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL rmid_ctrl: got %b want 0000", {gate, counter_reset, busy, result_valid});
    end
    total++;
    if ({result, windows} !== '0) begin bad++; $display("FAIL rmid_regs: got result %0d windows %0d want 0 0", result, windows); end
    duration = 3;
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      start = 1'b0;
      total++;
      if (result_valid !== (c == 8)) begin bad++; $display("FAIL rmid_valid cycle %0d: got %b want %b", c, result_valid, c == 8); end
      if (c == 8) begin
        total++;
        if (result !== model_cnt) begin bad++; $display("FAIL rmid_result: got %0d want %0d", result, model_cnt); end
        total++;
        if (windows !== 16'd1) begin bad++; $display("FAIL rmid_windows: got %0d want 1", windows); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_abort();
    test_continuous();
    test_ignored_starts();
    test_min_window();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
